// File: rtl/tlul_reg_device.sv
// TL-UL register file device: NumRegs 32-bit registers, one outstanding request.
// Optional response wait states are enabled by defining TLUL_DEV_WAIT_STATES_EN.
package tlul_pkg;
    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [7:0]  d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

module tlul_reg_device
    import tlul_pkg::*;
#(
    parameter int          NumRegs    = 16,
    parameter logic [31:0] BaseAddr   = 32'h0000_0000,
    parameter int          WaitCycles = 2
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  tl_h2d_t tl_i,
    output tl_d2h_t tl_o
);
    localparam int IdxW = (NumRegs > 1) ? $clog2(NumRegs) : 1;

`ifdef TLUL_DEV_WAIT_STATES_EN
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    logic [3:0] wait_cnt;
`else
    typedef enum logic [1:0] {IDLE, RESP} state_e;
`endif

    state_e      state;
    logic [31:0] regs [NumRegs];
    logic [2:0]  rsp_opcode;
    logic [1:0]  rsp_size;
    logic [7:0]  rsp_source;
    logic [31:0] rsp_data;
    logic        rsp_error;

    logic [32:0]     addr_ext;
    logic [32:0]     base_ext;
    logic [31:0]     offset;
    logic [IdxW-1:0] idx;
    logic            in_range;
    logic            op_ok;
    logic            is_put;
    logic            legal;
    logic            accept;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  mask);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = mask[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        return res;
    endfunction

    // 33-bit compare so a window ending at the top of the address space cannot wrap
    always_comb begin
        addr_ext = {1'b0, tl_i.a_address};
        base_ext = {1'b0, BaseAddr};
        offset   = tl_i.a_address - BaseAddr;
        idx      = IdxW'(offset >> 2);
        in_range = (addr_ext >= base_ext) && (addr_ext < base_ext + 33'(4 * NumRegs));
        is_put   = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
        op_ok    = is_put || (tl_i.a_opcode == Get);
        legal    = in_range && (tl_i.a_address[1:0] == 2'b00) && (tl_i.a_size <= 2'd2) && op_ok;
        accept   = tl_i.a_valid && (state == IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumRegs; i++) regs[i] <= '0;
        end else if (accept && legal && is_put) begin
            regs[idx] <= byte_merge(regs[idx], tl_i.a_data, tl_i.a_mask);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            rsp_opcode <= AccessAck;
            rsp_size   <= '0;
            rsp_source <= '0;
            rsp_data   <= '0;
            rsp_error  <= 1'b0;
`ifdef TLUL_DEV_WAIT_STATES_EN
            wait_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (tl_i.a_valid) begin
                        rsp_opcode <= (tl_i.a_opcode == Get) ? AccessAckData : AccessAck;
                        rsp_size   <= tl_i.a_size;
                        rsp_source <= tl_i.a_source;
                        rsp_data   <= (legal && tl_i.a_opcode == Get) ? regs[idx] : 32'h0;
                        rsp_error  <= !legal;
`ifdef TLUL_DEV_WAIT_STATES_EN
                        wait_cnt   <= '0;
                        state      <= (WaitCycles == 0) ? RESP : WAIT;
`else
                        state      <= RESP;
`endif
                    end
                end
`ifdef TLUL_DEV_WAIT_STATES_EN
                WAIT: begin
                    if (wait_cnt == 4'(WaitCycles - 1)) state <= RESP;
                    else wait_cnt <= wait_cnt + 4'd1;
                end
`endif
                RESP: begin
                    if (tl_i.d_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // d_valid follows state directly so an asynchronous reset drops it at once
    always_comb begin
        tl_o.d_valid  = (state == RESP);
        tl_o.d_opcode = rsp_opcode;
        tl_o.d_size   = rsp_size;
        tl_o.d_source = rsp_source;
        tl_o.d_sink   = rsp_source;
        tl_o.d_data   = rsp_data;
        tl_o.d_error  = rsp_error;
        tl_o.a_ready  = (state == IDLE) && !rst_i;
    end
endmodule

// File: tb/tb_tlul_reg_device.sv
// Directed bench for tlul_reg_device: writes, partial writes, errors, backpressure, reset.
module tb_tlul_reg_device;
    import tlul_pkg::*;

`ifdef TLUL_DEV_WAIT_STATES_EN
    localparam int ExpLat = 4;
`else
    localparam int ExpLat = 1;
`endif

    logic    clk = 1'b0;
    logic    rst = 1'b0;
    tl_h2d_t tl_i;
    tl_d2h_t tl_o;
    int      passed = 0;
    int      total  = 0;
    tl_d2h_t rsp;
    int      lat;

    tlul_reg_device #(.NumRegs(16), .BaseAddr(32'h0), .WaitCycles(3)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .tl_i (tl_i),
        .tl_o (tl_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic xact(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input logic [1:0] size, input logic [7:0] src,
                        input int hold, input logic [31:0] exp_data,
                        output tl_d2h_t r, output int l);
        int n = 0;
        while (!tl_o.a_ready && n < 20) begin @(posedge clk); #1; n++; end
        check("a_ready_idle", {31'b0, tl_o.a_ready}, 32'd1);
        tl_i.a_valid = 1'b1; tl_i.a_opcode = op; tl_i.a_address = addr; tl_i.a_data = data;
        tl_i.a_mask = mask; tl_i.a_size = size; tl_i.a_source = src;
        @(posedge clk); #1;
        tl_i.a_valid = 1'b0;
        l = 1;
        while (!tl_o.d_valid && l < 20) begin @(posedge clk); #1; l++; end
        r = tl_o;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_d_valid", {31'b0, tl_o.d_valid}, 32'd1);
            check("hold_d_data", tl_o.d_data, exp_data);
            check("hold_a_ready", {31'b0, tl_o.a_ready}, 32'd0);
        end
        tl_i.d_ready = 1'b1;
        @(posedge clk); #1;
        tl_i.d_ready = 1'b0;
    endtask

    initial begin
        tl_i = '0;
        #1 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("rst_a_ready", {31'b0, tl_o.a_ready}, 32'd0);
        check("rst_d_valid", {31'b0, tl_o.d_valid}, 32'd0);
        check("rst_d_error", {31'b0, tl_o.d_error}, 32'd0);
        check("rst_d_data", tl_o.d_data, 32'd0);
        check("rst_d_opcode", {29'b0, tl_o.d_opcode}, {29'b0, AccessAck});
        check("rst_d_source", {24'b0, tl_o.d_source}, 32'd0);
        @(negedge clk) rst = 1'b0;
        #1 check("a_ready_after_rst", {31'b0, tl_o.a_ready}, 32'd1);

        // Full write then read back
        xact(PutFullData, 32'h8, 32'hDEADBEEF, 4'hF, 2'd2, 8'd1, 0, 32'h0, rsp, lat);
        check("put8_latency", lat, ExpLat);
        check("put8_opcode", {29'b0, rsp.d_opcode}, {29'b0, AccessAck});
        check("put8_error", {31'b0, rsp.d_error}, 32'd0);
        check("put8_data", rsp.d_data, 32'd0);
        check("put8_source", {24'b0, rsp.d_source}, 32'd1);
        xact(Get, 32'h8, 32'h0, 4'hF, 2'd2, 8'd2, 0, 32'h0, rsp, lat);
        check("get8_opcode", {29'b0, rsp.d_opcode}, {29'b0, AccessAckData});
        check("get8_data", rsp.d_data, 32'hDEADBEEF);
        check("get8_error", {31'b0, rsp.d_error}, 32'd0);
        check("get8_size", {30'b0, rsp.d_size}, 32'd2);

        // Partial write keeps bytes 1 and 3
        xact(PutFullData, 32'h4, 32'h11223344, 4'hF, 2'd2, 8'd3, 0, 32'h0, rsp, lat);
        xact(PutPartialData, 32'h4, 32'hAABBCCDD, 4'b0101, 2'd2, 8'd3, 0, 32'h0, rsp, lat);
        check("partial_error", {31'b0, rsp.d_error}, 32'd0);
        xact(Get, 32'h4, 32'h0, 4'hF, 2'd2, 8'd3, 0, 32'h0, rsp, lat);
        check("get4_partial", rsp.d_data, 32'h11BB33DD);

        // Error responses
        xact(Get, 32'h40, 32'h0, 4'hF, 2'd2, 8'd4, 0, 32'h0, rsp, lat);
        check("oor_error", {31'b0, rsp.d_error}, 32'd1);
        check("oor_data", rsp.d_data, 32'd0);
        xact(Get, 32'h6, 32'h0, 4'hF, 2'd2, 8'd4, 0, 32'h0, rsp, lat);
        check("misalign_error", {31'b0, rsp.d_error}, 32'd1);
        check("misalign_data", rsp.d_data, 32'd0);
        xact(PutFullData, 32'h8, 32'h12345678, 4'hF, 2'd3, 8'd4, 0, 32'h0, rsp, lat);
        check("size3_error", {31'b0, rsp.d_error}, 32'd1);
        check("size3_size", {30'b0, rsp.d_size}, 32'd3);
        xact(3'h2, 32'h4, 32'hFFFFFFFF, 4'hF, 2'd2, 8'd4, 0, 32'h0, rsp, lat);
        check("badop_error", {31'b0, rsp.d_error}, 32'd1);
        check("badop_opcode", {29'b0, rsp.d_opcode}, {29'b0, AccessAck});
        xact(Get, 32'h8, 32'h0, 4'hF, 2'd2, 8'd4, 0, 32'h0, rsp, lat);
        check("get8_unchanged", rsp.d_data, 32'hDEADBEEF);
        xact(Get, 32'h4, 32'h0, 4'hF, 2'd2, 8'd4, 0, 32'h0, rsp, lat);
        check("get4_unchanged", rsp.d_data, 32'h11BB33DD);

        // Backpressure: response held for 5 cycles
        xact(Get, 32'h8, 32'h0, 4'hF, 2'd2, 8'd6, 5, 32'hDEADBEEF, rsp, lat);
        check("bp_d_valid_after", {31'b0, tl_o.d_valid}, 32'd0);
        check("bp_a_ready_after", {31'b0, tl_o.a_ready}, 32'd1);

        // Reset pulse while a response is pending
        tl_i.a_valid = 1'b1; tl_i.a_opcode = Get; tl_i.a_address = 32'h8;
        tl_i.a_size = 2'd2; tl_i.a_source = 8'd5; tl_i.a_mask = 4'hF;
        @(posedge clk); #1;
        tl_i.a_valid = 1'b0;
        lat = 1;
        while (!tl_o.d_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        check("rstmid_latency", lat, ExpLat);
        check("rstmid_d_source", {24'b0, tl_o.d_source}, 32'd5);
        check("rstmid_d_sink", {24'b0, tl_o.d_sink}, 32'd5);
        #2 rst = 1'b1;
        #1 check("rstmid_d_valid_async", {31'b0, tl_o.d_valid}, 32'd0);
        check("rstmid_a_ready", {31'b0, tl_o.a_ready}, 32'd0);
        @(negedge clk) rst = 1'b0;
        #1 check("rstmid_a_ready_after", {31'b0, tl_o.a_ready}, 32'd1);
        xact(Get, 32'h8, 32'h0, 4'hF, 2'd2, 8'd5, 0, 32'h0, rsp, lat);
        check("post_rst_get8", rsp.d_data, 32'd0);
        check("post_rst_error", {31'b0, rsp.d_error}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
